// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose: single-port data memory with a valid/ready request channel and a
// valid/ready response channel. Each accepted request waits WAIT_CYCLES
// cycles, then touches the memory and presents one response that is held
// until the initiator takes it. Only one request is in flight at a time.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  request present            req_ready  block can accept
//   req_we     1 = store, 0 = load        req_byte   1 = byte access
//   req_addr   byte address               req_wdata  store data
//   rsp_valid  response present           rsp_ready  initiator takes it
//   rsp_rdata  load data (0 on store/err) rsp_err    misaligned/out of range
//
// Configuration macro:
//   DMEM_BYTE_ACCESS_EN  enables byte loads/stores (little-endian lane
//                        req_addr[1:0], zero-extended loads). Without it
//                        req_byte is ignored and every access is a word.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

`ifdef DMEM_BYTE_ACCESS_EN
  logic        byte_q, byte_d;
`else
  logic        byte_unused;
  assign byte_unused = req_byte;
`endif

  logic          accept;
  logic [31:0]   acc_addr, acc_wdata;
  logic          acc_we, acc_byte;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_lane;
  logic          acc_oor, acc_mis, acc_err;
  logic          enter_resp;
  logic          mem_we;
  logic [31:0]   mem_rd, mem_wr;

  assign req_ready = (state_q == IDLE) && reset;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  // With zero wait states the memory is touched on the accept edge itself,
  // so the access uses the live request; otherwise it uses the latched copy.
  always_comb begin
    acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    acc_we    = (state_q == IDLE) ? req_we    : we_q;
`ifdef DMEM_BYTE_ACCESS_EN
    acc_byte  = (state_q == IDLE) ? req_byte  : byte_q;
`else
    acc_byte  = 1'b0;
`endif
    acc_idx   = acc_addr[AW+1:2];
    acc_lane  = acc_addr[1:0];
    acc_oor   = (acc_addr[31:AW+2] != '0);
    acc_mis   = !acc_byte && (acc_lane != 2'b00);
    acc_err   = acc_oor || acc_mis;

    enter_resp = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                 ((state_q == BUSY) && (cnt_q == 4'd0));

    // A byte store is a read-modify-write of the addressed word.
    mem_rd = mem_q[acc_idx];
    mem_wr = acc_wdata;
    if (acc_byte) begin
      mem_wr = mem_rd;
      mem_wr[{acc_lane, 3'b000} +: 8] = acc_wdata[7:0];
    end
    mem_we = enter_resp && acc_we && !acc_err;
  end

  // Next-state, wait counter and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
`ifdef DMEM_BYTE_ACCESS_EN
    byte_d  = byte_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
`ifdef DMEM_BYTE_ACCESS_EN
          byte_d  = req_byte;
`endif
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response registers: captured on the edge entering RESP, held while the
  // initiator stalls, cleared when the response is taken.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d = acc_err;
      if (acc_err || acc_we) begin
        rdata_d = 32'd0;
      end else if (acc_byte) begin
        rdata_d = {24'd0, mem_rd[{acc_lane, 3'b000} +: 8]};
      end else begin
        rdata_d = mem_rd;
      end
    end else if ((state_q == RESP) && rsp_ready) begin
      rdata_d = 32'd0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
`ifdef DMEM_BYTE_ACCESS_EN
      byte_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_BYTE_ACCESS_EN
      byte_q  <= byte_d;
`endif
    end
  end

  // Storage is deliberately outside the reset domain so contents survive
  // reset; an aborted transaction never reaches enter_resp, so never writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= mem_wr;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Testbench for dmem_responder (DEPTH=64, WAIT_CYCLES=2). A transaction-level
// model tracks memory contents and when each response is due; a compare
// process checks the DUT handshake and response outputs against it every
// cycle. Directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int WAIT  = 2;
   localparam int AW    = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic        req_byte = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_ready = 1'b0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_byte  (req_byte),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   // Single place where comparisons are counted and failures reported.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Transaction-level model: memory image, plus the one in-flight request and
   // the edge number at which its response becomes due.
   logic [31:0] m_mem [DEPTH];
   bit          m_pend = 1'b0;
   bit          m_resp = 1'b0;
   int          m_edge = 0;
   int          m_acc  = 0;
   logic        t_we, t_byte;
   logic [31:0] t_addr, t_wdata;
   logic [31:0] m_rdata = 32'd0;
   logic        m_err = 1'b0;

   // Apply the captured request to the memory image and form the response.
   task automatic modelCommit();
      logic [AW-1:0] idx;
      int            lane;
      bit            bacc;
      bit            oor;
      idx  = t_addr[AW+1:2];
      lane = int'(t_addr[1:0]);
`ifdef DMEM_BYTE_ACCESS_EN
      bacc = t_byte;
`else
      bacc = 1'b0;
`endif
      oor   = (t_addr >= 32'(4 * DEPTH));
      m_err = oor || (!bacc && (lane != 0));
      if (m_err) begin
         m_rdata = 32'd0;
      end else if (t_we) begin
         m_rdata = 32'd0;
         if (bacc) m_mem[idx][lane*8 +: 8] = t_wdata[7:0];
         else      m_mem[idx] = t_wdata;
      end else if (bacc) begin
         m_rdata = (m_mem[idx] >> (lane * 8)) & 32'h0000_00FF;
      end else begin
         m_rdata = m_mem[idx];
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_pend = 1'b0;
            m_resp = 1'b0;
         end else begin
            m_edge++;
            if (m_resp) begin
               if (rsp_ready) m_resp = 1'b0;
            end else if (!m_pend && req_valid) begin
               t_we    = req_we;
               t_byte  = req_byte;
               t_addr  = req_addr;
               t_wdata = req_wdata;
               m_acc   = m_edge;
               m_pend  = 1'b1;
            end
            if (m_pend && (m_edge == m_acc + WAIT)) begin
               modelCommit();
               m_pend = 1'b0;
               m_resp = 1'b1;
            end
         end
      end
   end

   // Compare process: every cycle, a little after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         checkOutput("req_ready", 32'(req_ready), 32'(reset && !m_pend && !m_resp));
         checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_resp));
         if (m_resp) begin
            checkOutput("rsp_rdata", rsp_rdata, m_rdata);
            checkOutput("rsp_err", 32'(rsp_err), 32'(m_err));
         end else if (!reset) begin
            checkOutput("rst_rdata", rsp_rdata, 32'd0);
            checkOutput("rst_err", 32'(rsp_err), 32'd0);
         end
      end
   end

   // One complete transaction. Between accept and release the request
   // inputs are scribbled with junk, which the DUT must ignore.
   task automatic applyStimulus(input logic we, input logic byt, input logic [31:0] addr,
                                input logic [31:0] wdata, input int hold,
                                output logic [31:0] rd, output logic er, output int lat);
      bit done;
      bit got;
      done = 1'b0;
      got  = 1'b0;
      rd   = 32'hFFFF_FFFF;
      er   = 1'bx;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_byte  = byt;
      req_addr  = addr;
      req_wdata = wdata;
      rsp_ready = 1'b0;
      @(posedge clk);
      lat = 1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            if (!got) begin
               got = 1'b1;
               rd  = rsp_rdata;
               er  = rsp_err;
            end
            if (hold > 0) begin
               hold--;
               rsp_ready = 1'b0;
               req_valid = 1'($urandom);
               req_addr  = $urandom;
               req_wdata = $urandom;
               req_we    = 1'($urandom);
            end else begin
               rsp_ready = 1'b1;
               req_valid = 1'b0;
               done      = 1'b1;
            end
         end else begin
            lat++;
            rsp_ready = 1'($urandom);
            req_valid = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_we    = 1'($urandom);
            req_byte  = 1'($urandom);
         end
         @(posedge clk);
      end
      if (!done) begin
         checkOutput("rsp_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
      end
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rdata", rsp_rdata, 32'd0);
      checkOutput("reset_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

      // Fill every word so later loads have defined contents.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, 32'(i * 4), $urandom, 0, rd, er, lat);
      end

      // Store then load 0x10, with latency pinned.
      applyStimulus(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
      checkOutput("st10_lat", 32'(lat), 32'd3);
      checkOutput("st10_rdata", rd, 32'd0);
      checkOutput("st10_err", 32'(er), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h10, 32'd0, 0, rd, er, lat);
      checkOutput("ld10_lat", 32'(lat), 32'd3);
      checkOutput("ld10_rdata", rd, 32'hDEAD_BEEF);
      checkOutput("ld10_err", 32'(er), 32'd0);

      // Misaligned word load.
      applyStimulus(1'b0, 1'b0, 32'h12, 32'd0, 0, rd, er, lat);
      checkOutput("ld12_err", 32'(er), 32'd1);
      checkOutput("ld12_rdata", rd, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h10, 32'd0, 0, rd, er, lat);
      checkOutput("ld10_again", rd, 32'hDEAD_BEEF);

      // Out-of-range store (first address past the array).
      applyStimulus(1'b1, 1'b0, 32'h100, 32'h5555_AAAA, 0, rd, er, lat);
      checkOutput("st100_err", 32'(er), 32'd1);
      checkOutput("st100_rdata", rd, 32'd0);

      // Stalled response: the compare process checks stability every cycle.
      applyStimulus(1'b0, 1'b0, 32'h10, 32'd0, 5, rd, er, lat);
      checkOutput("hold_rdata", rd, 32'hDEAD_BEEF);

      // Reset one cycle after a store accept aborts it.
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h1234_5678, 0, rd, er, lat);
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_byte  = 1'b0;
      req_addr  = 32'h20;
      req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'h20, 32'd0, 0, rd, er, lat);
      checkOutput("abort_ld20", rd, 32'h1234_5678);
      checkOutput("abort_ld20_err", 32'(er), 32'd0);

`ifdef DMEM_BYTE_ACCESS_EN
      applyStimulus(1'b1, 1'b0, 32'h30, 32'h1122_3344, 0, rd, er, lat);
      applyStimulus(1'b1, 1'b1, 32'h31, 32'hFFFF_FFAA, 0, rd, er, lat);
      checkOutput("stb31_err", 32'(er), 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h31, 32'd0, 0, rd, er, lat);
      checkOutput("ldb31", rd, 32'h0000_00AA);
      applyStimulus(1'b0, 1'b0, 32'h30, 32'd0, 0, rd, er, lat);
      checkOutput("ld30_merged", rd, 32'h1122_AA44);
`else
      // req_byte is ignored: an odd byte address is a misaligned word access.
      applyStimulus(1'b1, 1'b0, 32'h30, 32'h1122_3344, 0, rd, er, lat);
      applyStimulus(1'b1, 1'b1, 32'h31, 32'hFFFF_FFAA, 0, rd, er, lat);
      checkOutput("stb31_err", 32'(er), 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h30, 32'd0, 0, rd, er, lat);
      checkOutput("ldb30_word", rd, 32'h1122_3344);
`endif

      // Randomized traffic, checked by the model.
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         int          sel;
         sel = int'($urandom_range(0, 7));
         if (sel <= 4)      a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
         else if (sel == 5) a = 32'($urandom_range(0, 4 * DEPTH - 1));
         else if (sel == 6) a = 32'(4 * DEPTH + $urandom_range(0, 63));
         else               a = $urandom;
         applyStimulus(1'($urandom), 1'($urandom), a, $urandom, int'($urandom_range(0, 2)),
                       rd, er, lat);
      end

      // Full readback; the compare process checks each word.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 32'(i * 4), 32'd0, 0, rd, er, lat);
      end

      @(negedge clk);
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #4;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
